// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard-controller output bundle, decode-control modes
// and small helpers used by the ID-stage control logic.
package pipeline_pkg;

  localparam int MD_LAT_DEFAULT = 8;
  localparam int REG_W          = 5;

  typedef enum logic [1:0] {
    CTL_RUN       = 2'd0,
    CTL_FREEZE    = 2'd1,
    CTL_FLUSH     = 2'd2,
    CTL_INTERLOCK = 2'd3
  } ctl_mode_t;

  typedef struct packed {
    logic             stall;
    logic             ex_bubble;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [REG_W-1:0] md_rd;
  } hz_out_t;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/md_tracker.sv
// Tracks the single in-flight mul/div: destination register and cycles left
// until its result is ready for writeback.
module md_tracker
  import pipeline_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REG_W-1:0] start_rd,
  input  logic             freeze,
  output logic             busy,
  output logic             done,
  output logic [REG_W-1:0] rd
);

  localparam int CNT_W = $clog2(MD_LAT);

  logic [CNT_W-1:0] md_cnt;

  // A frozen cycle neither counts nor retires, so done stays a single pulse.
  assign done = busy && (md_cnt == '0) && !freeze;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy   <= 1'b0;
      md_cnt <= '0;
      rd     <= '0;
    end else if (!freeze) begin
      if (start) begin
        busy   <= 1'b1;
        rd     <= start_rd;
        md_cnt <= CNT_W'(MD_LAT - 1);
      end else if (done) begin
        busy <= 1'b0;
      end else if (busy) begin
        md_cnt <= md_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use and mul/div interlocks, memory
// freeze, branch flush, and issue of a single multi-cycle mul/div.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_w_rd,
  input  logic             id_is_load,
  input  logic             id_is_md,
  input  logic             ex_branch,
  input  logic             mem_wait,
  output logic             stall,
  output logic             ex_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [REG_W-1:0] md_rd
);

  logic             ld_v;
  logic [REG_W-1:0] ld_rd;
  logic             trk_busy;
  logic             trk_done;
  logic [REG_W-1:0] trk_rd;
  logic             hz_load_use;
  logic             hz_md;
  logic             issue;
  ctl_mode_t        mode;
  hz_out_t          hz;

  always_comb begin
    hz_load_use = ld_v &&
                  ((id_use_rs1 && reg_match(id_rs1, ld_rd)) ||
                   (id_use_rs2 && reg_match(id_rs2, ld_rd)));
    // Busy is still set during the done cycle, so md hazards hold through it.
    hz_md = trk_busy &&
            ((id_use_rs1 && reg_match(id_rs1, trk_rd)) ||
             (id_use_rs2 && reg_match(id_rs2, trk_rd)) ||
             (id_w_rd    && reg_match(id_rd,  trk_rd)) ||
             id_is_md);
  end

  always_comb begin
    mode = CTL_RUN;
    if (mem_wait)
      mode = CTL_FREEZE;
    else if (ex_branch)
      mode = CTL_FLUSH;
    else if (id_valid && (hz_load_use || hz_md))
      mode = CTL_INTERLOCK;
  end

  assign issue = rst && (mode == CTL_RUN) && id_valid;

  always_comb begin
    hz           = '0;
    hz.md_busy   = trk_busy;
    hz.md_rd     = trk_rd;
    hz.md_start  = issue && id_is_md;
    hz.md_done   = rst && trk_done;
    hz.ex_bubble = 1'b1;
    if (rst) begin
      case (mode)
        CTL_FREEZE: begin
          hz.stall     = 1'b1;
          hz.ex_bubble = 1'b0;
        end
        CTL_FLUSH: begin
          hz.stall     = 1'b0;
          hz.ex_bubble = 1'b1;
        end
        CTL_INTERLOCK: begin
          hz.stall     = 1'b1;
          hz.ex_bubble = 1'b1;
        end
        default: begin
          hz.stall     = 1'b0;
          hz.ex_bubble = !id_valid;
        end
      endcase
    end
  end

  // EX-stage load tracking: only a load that actually issues can create a use hazard.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_v <= 1'b0;
    end else if (!mem_wait) begin
      ld_v  <= issue && id_is_load && id_w_rd;
      ld_rd <= id_rd;
    end
  end

  md_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_tracker (
    .clk      (clk),
    .rst      (rst),
    .start    (hz.md_start),
    .start_rd (id_rd),
    .freeze   (mem_wait),
    .busy     (trk_busy),
    .done     (trk_done),
    .rd       (trk_rd)
  );

  assign stall     = hz.stall;
  assign ex_bubble = hz.ex_bubble;
  assign md_start  = hz.md_start;
  assign md_busy   = hz.md_busy;
  assign md_done   = hz.md_done;
  assign md_rd     = hz.md_rd;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the decode hazard rules.
module tb_hazard_ctrl;

  localparam int LAT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_w_rd, id_is_load, id_is_md;
  logic       ex_branch, mem_wait;
  logic       stall, ex_bubble, md_start, md_busy, md_done;
  logic [4:0] md_rd;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit       m_ld_v;
  bit [4:0] m_ld_rd;
  bit       m_busy;
  bit [4:0] m_rd;
  int       m_elapsed;   // non-frozen cycles seen since the mul/div issued
  bit       e_stall, e_bub, e_start, e_done;

  hazard_ctrl #(.MD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_w_rd(id_w_rd),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .ex_branch(ex_branch),
    .mem_wait(mem_wait), .stall(stall), .ex_bubble(ex_bubble), .md_start(md_start),
    .md_busy(md_busy), .md_done(md_done), .md_rd(md_rd)
  );

  always #5 clk = ~clk;

  function automatic bit dep(input bit [4:0] a, input bit [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic bit model_hazard();
    bit srcs_ld, srcs_md;
    srcs_ld = m_ld_v && ((id_use_rs1 && dep(id_rs1, m_ld_rd)) || (id_use_rs2 && dep(id_rs2, m_ld_rd)));
    srcs_md = m_busy && ((id_use_rs1 && dep(id_rs1, m_rd)) || (id_use_rs2 && dep(id_rs2, m_rd)) ||
                         (id_w_rd && dep(id_rd, m_rd)) || id_is_md);
    return srcs_ld || srcs_md;
  endfunction

  task automatic model_eval();
    bit go;
    e_done = 0; e_start = 0;
    if (!rst) begin
      e_stall = 0; e_bub = 1;
    end else if (mem_wait) begin
      e_stall = 1; e_bub = 0;
    end else if (ex_branch) begin
      e_stall = 0; e_bub = 1;
    end else if (id_valid && model_hazard()) begin
      e_stall = 1; e_bub = 1;
    end else begin
      e_stall = 0; e_bub = !id_valid;
    end
    go = rst && !mem_wait && !ex_branch && id_valid && !model_hazard();
    e_start = go && id_is_md;
    e_done  = rst && !mem_wait && m_busy && (m_elapsed == LAT);
  endtask

  task automatic model_update();
    bit go;
    if (!rst) begin
      m_ld_v = 0; m_busy = 0; m_rd = 0; m_elapsed = 0;
    end else if (!mem_wait) begin
      go = !ex_branch && id_valid && !model_hazard();
      if (m_busy && m_elapsed == LAT) m_busy = 0;
      else if (m_busy) m_elapsed++;
      m_ld_v  = go && id_is_load && id_w_rd;
      m_ld_rd = id_rd;
      if (go && id_is_md) begin
        m_busy = 1; m_rd = id_rd; m_elapsed = 1;
      end
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2ns after posedge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_w_rd = 0; id_is_load = 0; id_is_md = 0; ex_branch = 0; mem_wait = 0;
  endtask

  task automatic instr(input bit [4:0] rd, input bit w, input bit [4:0] rs1, input bit u1,
                       input bit [4:0] rs2, input bit u2, input bit ld, input bit md);
    idle();
    id_valid = 1; id_rd = rd; id_w_rd = w; id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2; id_is_load = ld; id_is_md = md;
  endtask

  task automatic do_reset();
    rst = 0; idle(); tick(); rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    instr(5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 1);
    ex_branch = 1;
    settle();
    checks++;
    if (stall !== 1'b0 || ex_bubble !== 1'b1 || md_start !== 1'b0 || md_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b bub=%b start=%b done=%b want 0 1 0 0",
               stall, ex_bubble, md_start, md_done);
    end
    tick();
    rst = 1; idle(); settle();
    checks++;
    if (md_busy !== 1'b0 || md_rd !== 5'd0 || stall !== 1'b0 || ex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got busy=%b rd=%0d stall=%b bub=%b want 0 0 0 1",
               md_busy, md_rd, stall, ex_bubble);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    instr(5'd5, 1, 5'd1, 1, 5'd0, 0, 1, 0); settle();
    checks++;
    if (stall !== 1'b0 || ex_bubble !== 1'b0) begin
      errors++; $display("FAIL load_issue got stall=%b bub=%b want 0 0", stall, ex_bubble);
    end
    tick();
    instr(5'd6, 1, 5'd5, 1, 5'd7, 1, 0, 0); settle();
    checks++;
    if (stall !== 1'b1 || ex_bubble !== 1'b1) begin
      errors++; $display("FAIL load_use_stall got stall=%b bub=%b want 1 1", stall, ex_bubble);
    end
    tick(); settle();
    checks++;
    if (stall !== 1'b0 || ex_bubble !== 1'b0) begin
      errors++; $display("FAIL load_use_release got stall=%b bub=%b want 0 0", stall, ex_bubble);
    end
    tick();
    instr(5'd0, 1, 5'd1, 1, 5'd0, 0, 1, 0); settle(); tick();
    instr(5'd6, 1, 5'd0, 1, 5'd0, 1, 0, 0); settle();
    checks++;
    if (stall !== 1'b0 || ex_bubble !== 1'b0) begin
      errors++; $display("FAIL load_use_x0 got stall=%b bub=%b want 0 0", stall, ex_bubble);
    end
    tick();
  endtask

  task automatic test_mul_latency();
    do_reset();
    instr(5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 1); settle();
    checks++;
    if (md_start !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL mul_start got start=%b stall=%b want 1 0", md_start, stall);
    end
    tick();
    instr(5'd4, 1, 5'd3, 1, 5'd1, 1, 0, 0);
    for (int i = 1; i <= LAT; i++) begin
      settle();
      checks++;
      if (stall !== 1'b1 || md_done !== (i == LAT) || md_busy !== 1'b1 || md_rd !== 5'd3) begin
        errors++;
        $display("FAIL mul_wait_t%0d got stall=%b done=%b busy=%b rd=%0d want 1 %b 1 3",
                 i, stall, md_done, md_busy, md_rd, (i == LAT));
      end
      tick();
    end
    settle();
    checks++;
    if (stall !== 1'b0 || md_busy !== 1'b0 || md_done !== 1'b0) begin
      errors++; $display("FAIL mul_dep_issue got stall=%b busy=%b done=%b want 0 0 0",
                         stall, md_busy, md_done);
    end
    tick();
  endtask

  task automatic test_md_struct_waw();
    int n;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      instr(5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 1); settle(); tick();
      if (k == 0) instr(5'd9, 1, 5'd1, 1, 5'd2, 1, 0, 1);
      else        instr(5'd3, 1, 5'd1, 1, 5'd0, 0, 0, 0);
      n = 0;
      settle();
      while (stall === 1'b1 && n < 40) begin
        tick(); settle(); n++;
      end
      checks++;
      if (n != LAT || md_start !== (k == 0)) begin
        errors++; $display("FAIL md_%s got stalls=%0d start=%b want %0d %b",
                           (k == 0) ? "struct" : "waw", n, md_start, LAT, (k == 0));
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    int done_at;
    do_reset();
    instr(5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 1); settle(); tick();
    idle();
    done_at = -1;
    for (int c = 1; c <= 16; c++) begin
      mem_wait = (c >= 4 && c <= 6);
      id_valid = 1; id_rd = 5'd8; id_w_rd = 1;
      settle();
      if (mem_wait) begin
        checks++;
        if (stall !== 1'b1 || ex_bubble !== 1'b0 || md_done !== 1'b0) begin
          errors++; $display("FAIL memwait_c%0d got stall=%b bub=%b done=%b want 1 0 0",
                             c, stall, ex_bubble, md_done);
        end
      end
      if (md_done === 1'b1 && done_at < 0) done_at = c;
      tick();
    end
    mem_wait = 0;
    checks++;
    if (done_at != LAT + 3) begin
      errors++; $display("FAIL memwait_done got cycle %0d want %0d", done_at, LAT + 3);
    end
  endtask

  task automatic test_branch();
    do_reset();
    instr(5'd5, 1, 5'd1, 1, 5'd0, 0, 1, 0); settle(); tick();
    instr(5'd6, 1, 5'd5, 1, 5'd7, 1, 0, 0); ex_branch = 1; settle();
    checks++;
    if (stall !== 1'b0 || ex_bubble !== 1'b1) begin
      errors++; $display("FAIL branch_flush got stall=%b bub=%b want 0 1", stall, ex_bubble);
    end
    tick();
    ex_branch = 0; settle();
    checks++;
    if (stall !== 1'b0 || ex_bubble !== 1'b0) begin
      errors++; $display("FAIL branch_ldv_clear got stall=%b bub=%b want 0 0", stall, ex_bubble);
    end
    tick();
  endtask

  task automatic test_reset_mid_md();
    int seen;
    do_reset();
    instr(5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 1); settle(); tick();
    idle();
    for (int c = 1; c <= LAT - 3; c++) begin settle(); tick(); end
    rst = 0; settle();
    checks++;
    if (md_busy !== 1'b1 || ex_bubble !== 1'b1 || stall !== 1'b0 || md_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_during got busy=%b bub=%b stall=%b done=%b want 1 1 0 0",
                         md_busy, ex_bubble, stall, md_done);
    end
    tick();
    rst = 1; settle();
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_busy got %b want 0", md_busy);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      settle(); if (md_done === 1'b1) seen++; tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rstmid_no_done got %0d done pulses want 0", seen);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      id_valid   = ($urandom_range(0, 9) < 8);
      id_rs1     = 5'($urandom_range(0, 4));
      id_rs2     = 5'($urandom_range(0, 4));
      id_rd      = 5'($urandom_range(0, 4));
      id_use_rs1 = $urandom_range(0, 1);
      id_use_rs2 = $urandom_range(0, 1);
      id_w_rd    = ($urandom_range(0, 3) != 0);
      id_is_load = ($urandom_range(0, 3) == 0);
      id_is_md   = !id_is_load && ($urandom_range(0, 4) == 0);
      ex_branch  = ($urandom_range(0, 9) == 0);
      mem_wait   = ($urandom_range(0, 6) == 0);
      rst        = ($urandom_range(0, 99) != 0);
      settle();
      checks++;
      if (stall !== e_stall || ex_bubble !== e_bub || md_start !== e_start ||
          md_done !== e_done || md_busy !== m_busy || (m_busy && md_rd !== m_rd)) begin
        errors++;
        $display("FAIL random_c%0d got st=%b bb=%b s=%b d=%b busy=%b rd=%0d want %b %b %b %b %b %0d",
                 c, stall, ex_bubble, md_start, md_done, md_busy, md_rd,
                 e_stall, e_bub, e_start, e_done, m_busy, m_rd);
      end
      tick();
    end
    rst = 1; idle();
  endtask

  initial begin
    rst = 0; idle();
    m_ld_v = 0; m_ld_rd = 0; m_busy = 0; m_rd = 0; m_elapsed = 0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_mul_latency();
    test_md_struct_waw();
    test_mem_wait();
    test_branch();
    test_reset_mid_md();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller and issue scheduler for the decode stage. It watches the instruction in ID and the state of the downstream stages, and drives the stall and bubble controls for the ID→EX boundary. It handles load-use interlocks, memory-wait freeze, branch flush, and the issue and tracking of one multi-cycle mul/div operation. It sits beside the ID stage: its outputs gate the IF/ID registers and the bubble bit passed to EX.

## Interface

Parameters:
- `MD_LAT`, default 8: mul/div latency in cycles from issue to `md_done`. Legal range 2..32.

Ports:
- `clk`, input, 1: single clock. All state changes on posedge.
- `rst`, input, 1: synchronous, active-low reset.
- `id_valid`, input, 1: ID holds a real instruction (not a bubble).
- `id_rs1`, `id_rs2`, input, 5 each: source registers of the ID instruction.
- `id_use_rs1`, `id_use_rs2`, input, 1 each: the ID instruction reads that source. Immediate operand2 means `id_use_rs2`=0.
- `id_rd`, input, 5: destination register of the ID instruction.
- `id_w_rd`, input, 1: the ID instruction writes `id_rd`.
- `id_is_load`, input, 1: the ID instruction is a load.
- `id_is_md`, input, 1: the ID instruction is mul/div.
- `ex_branch`, input, 1: a branch in EX is taken this cycle.
- `mem_wait`, input, 1: data memory is not ready.
- `stall`, output, 1: hold the IF and ID registers.
- `ex_bubble`, output, 1: EX receives a bubble next cycle.
- `md_start`, output, 1: one-cycle pulse that issues the ID mul/div.
- `md_busy`, output, 1: a mul/div is in flight.
- `md_done`, output, 1: one-cycle pulse; the mul/div result is ready for writeback.
- `md_rd`, output, 5: destination of the in-flight mul/div.

## Operation

Internal state:
- `ld_v` / `ld_rd`: a load currently in EX, and its destination.
- `md_busy`, `md_rd`, and countdown `md_cnt` of width $clog2(MD_LAT).

Hazard conditions. All comparisons ignore x0: a source or destination of 0 never matches.
- Load-use: `ld_v` && used source == `ld_rd`.
- MD RAW: `md_busy` && used source == `md_rd`.
- MD WAW: `md_busy` && `id_w_rd` && `id_rd` == `md_rd`.
- MD structural: `md_busy` && `id_is_md`.

Control outputs are combinational, evaluated in priority order:
1. `mem_wait`=1 → `stall`=1, `ex_bubble`=0. Full freeze: no state update, and `md_cnt` does not count.
2. `ex_branch`=1 → `stall`=0, `ex_bubble`=1. The ID instruction is killed.
3. `id_valid` && any hazard → `stall`=1, `ex_bubble`=1.
4. Otherwise → `stall`=0, `ex_bubble`=!`id_valid`. The instruction issues when `id_valid`=1.

Issue and state update, applied only when `mem_wait`=0:
- issue = priority-4 case with `id_valid`=1.
- `ld_v` ← issue && `id_is_load` && `id_w_rd`; `ld_rd` ← `id_rd`. `ld_v` clears on any non-issue cycle.
- `md_start` = issue && `id_is_md`. It sets `md_busy`=1, `md_rd`=`id_rd`, `md_cnt`=MD_LAT-1.
- While busy, `md_cnt` decrements by 1 per non-frozen cycle.
- `md_done` = `md_busy` && `md_cnt`==0.
- The cycle after `md_done`, `md_busy`=0.
- Hazards against `md_rd` remain active during the `md_done` cycle.
- A new mul/div can issue the cycle after `md_done` at the earliest.
- A taken branch does not cancel an in-flight mul/div. It was issued before the branch and is architecturally older.

## Timing

- Reset values (rst=0 at a posedge), with all inputs ignored that cycle:
  - `ld_v`=0, `md_busy`=0, `md_cnt`=0, `md_rd`=0.
  - `stall`=0, `ex_bubble`=1, `md_start`=0, `md_done`=0.
- Reset mid-mul/div drops the operation. No `md_done` is produced.
- A load-use hazard costs exactly 1 stall cycle.
- Mul/div latency is `md_start` → `md_done` = MD_LAT cycles, plus each `mem_wait` cycle.
- `md_start` and `md_done` never coincide.
- `stall` and `ex_bubble` depend on registered state plus same-cycle inputs. There is no added latency.

## Structure

- Add to `pipeline_pkg`:
  - `hz_out_t` struct holding `stall`, `ex_bubble`, `md_start`, `md_busy`, `md_done`, `md_rd`.
  - `MD_LAT_DEFAULT` = 8.
- One sub-module, `md_tracker`. It holds `md_busy`/`md_rd`/`md_cnt`, with inputs `start`, `rd`, and `freeze`, and outputs `busy`, `done`, and `rd`.

## Test plan

- Load x5 issued, next instruction `add x6,x5,x7` → 1 cycle with `stall`=1 and `ex_bubble`=1; the add issues the following cycle. The same case with rs=x0 → no stall.
- `mul x3` issues at cycle t with MD_LAT=8 → `md_start` at t, `md_done` at t+8. A following `add x4,x3,x1` stalls t+1..t+8 and issues at t+9.
- A second `div` during busy → stalls until the cycle after `md_done`, then `md_start` fires. A `md_rd` WAW (`addi x3`) stalls the same way.
- `mem_wait` high for 3 cycles during a mul/div at `md_cnt`=4 → `md_done` is delayed 3 cycles. `stall`=1 and `ex_bubble`=0 throughout.
- `ex_branch`=1 while ID has a load-use hazard → `stall`=0, `ex_bubble`=1, and `ld_v`=0 next cycle.
- `rst`=0 while `md_busy`=1 with `md_cnt`=2 → next cycle `md_busy`=0. No `md_done` is ever seen, and `ex_bubble`=1 during reset.
